// File: rtl/booth_seq_arb_if.sv
// Handshake bundle between the Booth multiplier sequencer/arbiter and its two
// requesters plus the shared datapath.
interface booth_seq_arb_if;
    logic req0;
    logic req1;
    logic q0;
    logic q_1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic carga_qm;
    logic carga_a;
    logic resta;
    logic desplaza;
    logic busy;
    logic fin;

    modport master (
        output req0, req1, q0, q_1,
        input  gnt0, gnt1, sel, carga_qm, carga_a, resta, desplaza, busy, fin
    );

    modport slave (
        input  req0, req1, q0, q_1,
        output gnt0, gnt1, sel, carga_qm, carga_a, resta, desplaza, busy, fin
    );
endinterface

// File: rtl/booth_seq_arb.sv
// Two-requester arbiter and control sequencer for a shared radix-2 Booth datapath.
// Define ARB_RR_EN for round-robin on simultaneous requests (default: requester 0 wins).
module booth_seq_arb #(
    parameter int N = 8
) (
    input logic            clk,
    input logic            reset_n,
    booth_seq_arb_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          gnt0_r, gnt1_r, sel_r, carga_qm_r, desplaza_r, busy_r, fin_r, eval_r;
    logic          win;

`ifdef ARB_RR_EN
    logic last_gnt;
    assign win = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
`else
    assign win = bus.req1 && !bus.req0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            sel_r      <= 1'b0;
            carga_qm_r <= 1'b0;
            desplaza_r <= 1'b0;
            busy_r     <= 1'b0;
            fin_r      <= 1'b0;
            eval_r     <= 1'b0;
`ifdef ARB_RR_EN
            last_gnt   <= 1'b1;
`endif
        end else begin
            carga_qm_r <= 1'b0;
            desplaza_r <= 1'b0;
            fin_r      <= 1'b0;
            eval_r     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state      <= LOAD;
                        gnt0_r     <= ~win;
                        gnt1_r     <= win;
                        sel_r      <= win;
                        busy_r     <= 1'b1;
                        carga_qm_r <= 1'b1;
`ifdef ARB_RR_EN
                        last_gnt   <= win;
`endif
                    end
                end
                LOAD: begin
                    cnt    <= CW'(N);
                    state  <= EVAL;
                    eval_r <= 1'b1;
                end
                EVAL: begin
                    state      <= SHIFT;
                    desplaza_r <= 1'b1;
                end
                SHIFT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        fin_r <= 1'b1;
                    end else begin
                        state  <= EVAL;
                        eval_r <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    gnt0_r <= 1'b0;
                    gnt1_r <= 1'b0;
                    sel_r  <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The datapath shifts Q at the end of SHIFT, so the add/sub decision must
    // see the live Q bits during EVAL rather than a registered copy.
    assign bus.carga_a  = eval_r & (bus.q0 ^ bus.q_1);
    assign bus.resta    = eval_r & bus.q0 & ~bus.q_1;
    assign bus.gnt0     = gnt0_r;
    assign bus.gnt1     = gnt1_r;
    assign bus.sel      = sel_r;
    assign bus.carga_qm = carga_qm_r;
    assign bus.desplaza = desplaza_r;
    assign bus.busy     = busy_r;
    assign bus.fin      = fin_r;
endmodule
